// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 encryptor.
// The key is expanded once into a word RAM; blocks run one round per cycle.
module aes_iter_core #(
  parameter int KEY_LEN  = 128,
  parameter int DATA_LEN = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid_in,
  input  logic [KEY_LEN-1:0]  cipher_key,
  output logic                key_ready,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] plain_text,
  output logic                data_ready,
  output logic                data_valid_out,
  output logic [DATA_LEN-1:0] cipher_text,
  input  logic                out_ready
);
  localparam int NK = KEY_LEN / 32;
  localparam int NUMS_OF_ROUND = NK + 6;
  localparam int NW = 4 * (NUMS_OF_ROUND + 1);
  localparam logic [3:0] NR4 = 4'(NUMS_OF_ROUND);
  localparam logic [2:0] NK_LAST = 3'(NK - 1);
  localparam logic [5:0] W_LAST = 6'(NW - 1);

  if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key
    $error("aes_iter_core: KEY_LEN must be 128, 192 or 256");
  end
  if (DATA_LEN != 128) begin : g_bad_data
    $error("aes_iter_core: DATA_LEN must be 128");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]),
            sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  typedef enum logic [2:0] {
    IDLE, KEY_EXP, READY, ROUND, DONE
  } state_t;

  state_t       state;
  logic         key_loaded;
  logic [3:0]   rnd;
  logic [5:0]   kidx;
  logic [2:0]   kmod;
  logic [7:0]   rcon;
  logic [127:0] st;
  logic [31:0]  w [NW];

  logic         key_take;
  logic         data_take;
  logic [127:0] rk0;
  logic [127:0] rk;
  logic [127:0] rnd_res;
  logic [31:0]  prev;
  logic [31:0]  tmp;
  logic [31:0]  new_word;
  logic [7:0]   sb [16];
  logic [7:0]   sr [16];
  logic [7:0]   mc [16];

  assign key_take  = key_valid_in && key_ready;
  assign data_take = data_valid_in && data_ready && !key_valid_in;
  assign rk0 = {w[0], w[1], w[2], w[3]};
  assign rk  = {w[{rnd, 2'd0}], w[{rnd, 2'd1}],
                w[{rnd, 2'd2}], w[{rnd, 2'd3}]};
  assign cipher_text = st;

  // Byte n of a block is column n/4, row n%4.
  always_comb begin
    rnd_res = '0;
    for (int n = 0; n < 16; n++)
      sb[n] = sbox(st[127-8*n -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      mc[4*c] = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1]
              ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2])
                ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2])
                ^ xt(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1]
                ^ sr[4*c+2] ^ xt(sr[4*c+3]);
    end
    for (int n = 0; n < 16; n++)
      rnd_res[127-8*n -: 8] = ((rnd == NR4) ? sr[n] : mc[n])
                            ^ rk[127-8*n -: 8];
  end

  always_comb begin
    prev = w[kidx - 6'd1];
    tmp  = prev;
    if (kmod == 3'd0)
      tmp = subw({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    else if (NK == 8 && kmod == 3'd4)
      tmp = subw(prev);
    new_word = w[kidx - 6'(NK)] ^ tmp;
  end

  always_ff @(posedge clk) begin
    if (key_take)
      for (int j = 0; j < NK; j++)
        w[j] <= cipher_key[KEY_LEN-1-32*j -: 32];
    else if (state == KEY_EXP)
      w[kidx] <= new_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      key_loaded     <= 1'b0;
      key_ready      <= 1'b0;
      data_ready     <= 1'b0;
      data_valid_out <= 1'b0;
      st             <= '0;
      rnd            <= '0;
      kidx           <= '0;
      kmod           <= '0;
      rcon           <= '0;
    end else begin
      unique case (state)
        IDLE, READY: begin
          key_ready  <= 1'b1;
          data_ready <= key_loaded;
          if (key_take) begin
            state      <= KEY_EXP;
            key_loaded <= 1'b0;
            key_ready  <= 1'b0;
            data_ready <= 1'b0;
            kidx       <= 6'(NK);
            kmod       <= 3'd0;
            rcon       <= 8'h01;
          end else if (data_take && key_loaded) begin
            state      <= ROUND;
            st         <= plain_text ^ rk0;
            rnd        <= 4'd1;
            key_ready  <= 1'b0;
            data_ready <= 1'b0;
          end
        end
        KEY_EXP: begin
          kidx <= kidx + 6'd1;
          kmod <= (kmod == NK_LAST) ? 3'd0 : kmod + 3'd1;
          if (kmod == 3'd0)
            rcon <= xt(rcon);
          if (kidx == W_LAST) begin
            state      <= READY;
            key_loaded <= 1'b1;
            key_ready  <= 1'b1;
            data_ready <= 1'b1;
          end
        end
        ROUND: begin
          st  <= rnd_res;
          rnd <= rnd + 4'd1;
          if (rnd == NR4) begin
            state          <= DONE;
            data_valid_out <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state          <= READY;
            data_valid_out <= 1'b0;
            key_ready      <= 1'b1;
            data_ready     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
